dct_coef_accum: RTL and testbench
=================================

Name: dct_coef_accum

Overview:
- Sits directly downstream of the 8-stage mult8ux8s pipeline (unsigned 8-bit pixel x signed Q1.7 cosine, 16-bit signed product).
- Tracks operand issue through the multiplier latency and accumulates each run of TERMS products into one DCT coefficient.
- Rounds and saturates the sum, then queues it in a 2-entry output buffer with a valid/ready handshake.
- Throttles the upstream sequencer so no finished coefficient is ever lost.

Parameters:
- MULT_LAT, 8, multiplier latency in clocks from operand presentation to product.
- TERMS, 8, products per coefficient.
- SHIFT, 7, fractional bits removed from the sum (cosine Q1.7).
- OUT_W, 12, signed coefficient output width.
- ACC_W, 19, accumulator width (16 + clog2(TERMS)).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- issue_valid  in  1  operands presented to the multiplier this cycle.
- issue_last  in  1  qualifies issue_valid; marks the last term of the coefficient.
- issue_ready  out  1  upstream may issue this cycle.
- prod  in  16  signed product from the multiplier's result output.
- out_valid  out  1  coefficient available at queue head.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  OUT_W  signed rounded, saturated coefficient.
- out_index  out  3  coefficient index 0..7; increments per popped entry, wraps 7->0.
- sat_flag  out  1  sticky: a coefficient was saturated.
- term_err  out  1  sticky: a run did not contain exactly TERMS products.

Behaviour:
- Reset: clk and rst_n are the only clock and reset; rst_n is synchronous, active-low, sampled on the rising edge of clk.
  - rst_n=0 at a clock edge clears the delay line, accumulator, term counter, queue, pop index, lasts_pending and both sticky flags.
  - Reset values: out_valid=0, out_data=0, out_index=0, sat_flag=0, term_err=0. issue_ready=1 from the first cycle after reset.
  - Products already inside the multiplier at reset are discarded; the multiplier has no reset, so its output is ignored until the cleared delay line delivers a valid.
- Issue acceptance:
  - An issue is accepted when issue_valid & issue_ready.
  - issue_valid while issue_ready=0 is ignored (not tracked); upstream must hold the operands.
- Delay line:
  - A MULT_LAT-deep shift register carries {v, last}. It loads {accepted, issue_last & accepted} every cycle.
  - Its tap (dv, dlast) is aligned with prod: an issue accepted in cycle t pairs with prod in cycle t+MULT_LAT.
- Accumulation:
  - On dv: acc <= (first ? 0 : acc) + sign_extend(prod). term_cnt increments, or loads 1 when first.
  - first is set at reset and after every dlast; it clears on any dv without dlast.
  - On dv & dlast the closing sum is acc_next = the value just computed.
  - If term_cnt_next != TERMS, term_err <= 1. The coefficient is still produced.
- Round and saturate (combinational on acc_next):
  - r = (acc_next + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift (round half up).
  - If r > 2^(OUT_W-1)-1, output 2047 and set sat_flag. If r < -2^(OUT_W-1), output -2048 and set sat_flag.
  - Otherwise output r[OUT_W-1:0].
- Output queue:
  - 2 entries, FIFO order. Push on dv & dlast; pop on out_valid & out_ready.
  - Simultaneous push and pop with count=2 is legal; count stays 2.
  - out_valid = (count != 0). out_data holds the head entry. out_data is held stable while out_valid & !out_ready.
- Throttle:
  - lasts_pending counts accepted issue_last entries still in the delay line. It increments on acceptance and decrements on dv & dlast; both in one cycle leaves it unchanged.
  - issue_ready = (count + lasts_pending) < 2, with count and lasts_pending both registered. This guarantees a push never meets a full queue.
  - Non-last issues are blocked too while the throttle is closed.
- Latency:
  - The last term is accepted at cycle t. The coefficient is pushed at the end of cycle t+MULT_LAT.
  - out_valid=1 in cycle t+MULT_LAT+1 (9 clocks with defaults).
- Single-term runs (issue_valid & issue_last with first=1) are legal; term_err is set when TERMS != 1.
- The multiplier forces a zero product when either operand is 0; this needs no special handling.

Test Plan:
- Reset, then 8 issues over cycles 0..7 with prod=+128 each, last on the 8th, out_ready=1 -> out_valid rises in cycle 16 with out_data=8, out_index=0, flags 0.
- Products -64,-64,...(x8) -> sum -512, out_data=-4. Products {+64, 0 x7} -> (64+64)>>>7 = 1, confirming half-up rounding.
- 8 products of +32640 -> acc=261120, r=2040, no saturation. Force prod=0x7FFF x8 -> r=2048 -> out_data=2047 and sat_flag=1 sticky.
- out_ready=0, issue 3 back-to-back coefficients -> issue_ready drops once 2 lasts are pending or queued. Only 2 entries are held; the third is accepted after one pop. All three are delivered in order with out_index 0,1,2.
- Run of 5 terms closed by last -> term_err=1, coefficient still emitted. Assert rst_n=0 for 1 cycle mid-run -> next run with 8 terms yields the correct sum and no stale products.
- Continuous streaming of 16 runs with out_ready toggling randomly -> no loss or duplication, and out_index wraps 7->0.

Source files
------------

// File: rtl/dct_coef_accum.sv
// DCT coefficient accumulator: tracks operands through the multiplier pipeline, sums each run of
// products, rounds/saturates the sum and hands it out through a 2-entry valid/ready queue.
module dct_coef_accum #(
    parameter int MULT_LAT = 8,
    parameter int TERMS    = 8,
    parameter int SHIFT    = 7,
    parameter int OUT_W    = 12,
    parameter int ACC_W    = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic             issue_last,
    output logic             issue_ready,
    input  logic [15:0]      prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [2:0]       out_index,
    output logic             sat_flag,
    output logic             term_err
);

    localparam int CW = $clog2(TERMS + 1) + 1;

    localparam logic signed [ACC_W:0] RND    = {{(ACC_W + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
    localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W + 1 - OUT_W){1'b0}}, 1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_LO = {{(ACC_W + 1 - OUT_W){1'b1}}, 1'b1, {(OUT_W - 1){1'b0}}};

    logic [MULT_LAT-1:0]     dv_q, dv_d;
    logic [MULT_LAT-1:0]     dl_q, dl_d;
    logic                    first_q, first_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [OUT_W-1:0]        mem0_q, mem0_d;
    logic [OUT_W-1:0]        mem1_q, mem1_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;
    logic [1:0]              lp_q, lp_d;
    logic [2:0]              idx_q, idx_d;
    logic                    sat_q, sat_d;
    logic                    terr_q, terr_d;

    logic                    accepted;
    logic                    dv;
    logic                    dlast;
    logic                    push;
    logic                    pop;
    logic signed [ACC_W-1:0] acc_next;
    logic [CW-1:0]           cnt_next;
    logic signed [ACC_W:0]   rnd_sum;
    logic signed [ACC_W:0]   r_full;
    logic [OUT_W-1:0]        coef;
    logic                    coef_sat;

    // Queue entries plus finished-but-in-flight runs never exceed the two queue slots.
    assign issue_ready = ({1'b0, count_q} + {1'b0, lp_q}) < 3'd2;
    assign accepted    = issue_valid & issue_ready;
    assign dv          = dv_q[MULT_LAT-1];
    assign dlast       = dl_q[MULT_LAT-1];
    assign push        = dv & dlast;
    assign out_valid   = (count_q != 2'd0);
    assign pop         = out_valid & out_ready;
    assign out_data    = rd_ptr_q ? mem1_q : mem0_q;
    assign out_index   = idx_q;
    assign sat_flag    = sat_q;
    assign term_err    = terr_q;

    always_comb begin
        acc_next = (first_q ? '0 : acc_q) + {{(ACC_W - 16){prod[15]}}, prod};
        cnt_next = first_q ? CW'(1) : ((&cnt_q) ? cnt_q : cnt_q + CW'(1));
        rnd_sum  = {acc_next[ACC_W-1], acc_next} + RND;
        r_full   = rnd_sum >>> SHIFT;
        coef_sat = 1'b0;
        if (r_full > SAT_HI) begin
            coef     = {1'b0, {(OUT_W - 1){1'b1}}};
            coef_sat = 1'b1;
        end else if (r_full < SAT_LO) begin
            coef     = {1'b1, {(OUT_W - 1){1'b0}}};
            coef_sat = 1'b1;
        end else begin
            coef = r_full[OUT_W-1:0];
        end
    end

    always_comb begin
        dv_d     = {dv_q[MULT_LAT-2:0], accepted};
        dl_d     = {dl_q[MULT_LAT-2:0], accepted & issue_last};
        first_d  = first_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        lp_d     = lp_q;
        idx_d    = idx_q;
        sat_d    = sat_q;
        terr_d   = terr_q;

        if (dv) begin
            acc_d   = acc_next;
            cnt_d   = cnt_next;
            first_d = dlast;
        end

        if (push) begin
            if (wr_ptr_q) mem1_d = coef;
            else          mem0_d = coef;
            wr_ptr_d = ~wr_ptr_q;
            if (coef_sat)                sat_d  = 1'b1;
            if (cnt_next != CW'(TERMS))  terr_d = 1'b1;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            idx_d    = idx_q + 3'd1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        unique case ({accepted & issue_last, push})
            2'b10:   lp_d = lp_q + 2'd1;
            2'b01:   lp_d = lp_q - 2'd1;
            default: lp_d = lp_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dv_q     <= '0;
            dl_q     <= '0;
            first_q  <= 1'b1;
            acc_q    <= '0;
            cnt_q    <= '0;
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            lp_q     <= '0;
            idx_q    <= '0;
            sat_q    <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            dv_q     <= dv_d;
            dl_q     <= dl_d;
            first_q  <= first_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            lp_q     <= lp_d;
            idx_q    <= idx_d;
            sat_q    <= sat_d;
            terr_q   <= terr_d;
        end
    end

endmodule

// File: tb/tb_dct_coef_accum.sv
// Bench for dct_coef_accum: an 8-stage multiplier stand-in feeds products, a scoreboard holds the
// expected {coefficient, index} pairs and a monitor compares every handshake against it.
module tb_dct_coef_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_last = 1'b0;
    logic        issue_ready;
    logic [15:0] prod;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic [2:0]  out_index;
    logic        sat_flag;
    logic        term_err;

    logic signed [15:0] op_prod = 16'sd0;
    logic signed [15:0] mpipe [8];

    int          checks = 0;
    int          failures = 0;
    logic [14:0] sb [$];
    int          exp_idx = 0;
    bit          exp_sat = 1'b0;
    bit          exp_terr = 1'b0;

    dct_coef_accum dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .issue_last (issue_last),
        .issue_ready(issue_ready),
        .prod       (prod),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .sat_flag   (sat_flag),
        .term_err   (term_err)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: whatever operand product is presented appears on prod 8 clocks later.
    always @(posedge clk) begin
        mpipe[0] <= op_prod;
        for (int i = 1; i < 8; i++) mpipe[i] <= mpipe[i-1];
    end
    assign prod = mpipe[7];

    // Every accepted output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [14:0] exp_e;
        #1;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_output got data=%0d index=%0d, scoreboard empty",
                         $signed(out_data), out_index);
            end else begin
                exp_e = sb.pop_front();
                if ({out_data, out_index} !== exp_e) begin
                    failures++;
                    $display("[TB] FAIL coef got data=%0d index=%0d expected data=%0d index=%0d",
                             $signed(out_data), out_index, $signed(exp_e[14:3]), exp_e[2:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_issue(input logic signed [15:0] p, input logic l);
        int w = 0;
        @(negedge clk);
        issue_valid = 1'b1;
        issue_last  = l;
        op_prod     = p;
        while (!issue_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL issue_timeout got issue_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        op_prod     = 16'($urandom);
    endtask

    // mode 0: all terms = val; mode 1: first term = val, rest 0; mode 2: random products.
    task automatic send_run(input int n, input int mode, input int val);
        int p [16];
        int sum = 0;
        int r;
        logic [11:0] d;
        bit s = 1'b0;
        logic signed [15:0] rv;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       p[i] = val;
                1:       p[i] = (i == 0) ? val : 0;
                default: begin rv = 16'($urandom); p[i] = int'(rv); end
            endcase
            sum += p[i];
        end
        r = (sum + 64) >>> 7;
        if (r > 2047)       begin d = 12'h7FF; s = 1'b1; end
        else if (r < -2048) begin d = 12'h800; s = 1'b1; end
        else                d = 12'(r);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                sb.push_back({d, 3'(exp_idx)});
                exp_idx  = (exp_idx + 1) % 8;
                exp_sat  = exp_sat | s;
                exp_terr = exp_terr | (n != 8);
            end
            do_issue(16'(p[i]), i == n - 1);
        end
    endtask

    task automatic drain();
        int w = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain got %0d outstanding expected 0", sb.size());
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_empty got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        exp_idx  = 0;
        exp_sat  = 1'b0;
        exp_terr = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 5;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b expected 0", out_valid); end
        if (out_data !== 12'd0) begin failures++; $display("[TB] FAIL reset_data got %0d expected 0", out_data); end
        if (out_index !== 3'd0) begin failures++; $display("[TB] FAIL reset_index got %0d expected 0", out_index); end
        if (sat_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_sat got %b expected 0", sat_flag); end
        if (term_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_terr got %b expected 0", term_err); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got %b expected 1", issue_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_run(8, 0, 128);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin issue_valid = 1'b0; issue_last = 1'b0; end
            checks++;
            if (out_valid !== (k == 9)) begin
                failures++;
                $display("[TB] FAIL latency k=%0d got out_valid=%b expected %b", k, out_valid, k == 9);
            end
        end
        drain();
        checks += 2;
        if (sat_flag !== exp_sat)   begin failures++; $display("[TB] FAIL basic_sat got %b expected %b", sat_flag, exp_sat); end
        if (term_err !== exp_terr) begin failures++; $display("[TB] FAIL basic_terr got %b expected %b", term_err, exp_terr); end
    endtask

    task automatic test_rounding();
        out_ready = 1'b1;
        send_run(8, 0, -64);
        send_run(8, 1, 64);
        idle();
        drain();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        send_run(8, 0, 32640);
        idle();
        drain();
        checks++;
        if (sat_flag !== 1'b0) begin failures++; $display("[TB] FAIL nosat got %b expected 0", sat_flag); end
        send_run(8, 0, 32767);
        send_run(8, 0, -32768);
        idle();
        drain();
        checks++;
        if (sat_flag !== 1'b1) begin failures++; $display("[TB] FAIL sat_sticky got %b expected 1", sat_flag); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send_run(8, 2, 0);
        send_run(8, 2, 0);
        idle();
        repeat (12) @(negedge clk);
        checks += 2;
        if (issue_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got %b expected 0", issue_ready); end
        if (out_valid !== 1'b1)   begin failures++; $display("[TB] FAIL full_valid got %b expected 1", out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (issue_ready !== 1'b1) begin failures++; $display("[TB] FAIL reopen_ready got %b expected 1", issue_ready); end
        send_run(8, 2, 0);
        idle();
        drain();
    endtask

    task automatic test_term_err();
        out_ready = 1'b1;
        send_run(5, 0, 100);
        idle();
        drain();
        checks++;
        if (term_err !== 1'b1) begin failures++; $display("[TB] FAIL term_err got %b expected 1", term_err); end
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) do_issue(16'sd1000, 1'b0);
        do_reset();
        @(negedge clk);
        checks += 3;
        if (term_err !== 1'b0)  begin failures++; $display("[TB] FAIL rst_terr got %b expected 0", term_err); end
        if (sat_flag !== 1'b0)  begin failures++; $display("[TB] FAIL rst_sat got %b expected 0", sat_flag); end
        if (out_index !== 3'd0) begin failures++; $display("[TB] FAIL rst_index got %0d expected 0", out_index); end
        send_run(8, 0, 200);
        idle();
        drain();
        checks++;
        if (term_err !== 1'b0) begin failures++; $display("[TB] FAIL post_rst_terr got %b expected 0", term_err); end
    endtask

    task automatic test_streaming();
        bit done = 1'b0;
        fork
            begin
                for (int r = 0; r < 16; r++) send_run(8, 2, 0);
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        checks += 2;
        if (sat_flag !== exp_sat)   begin failures++; $display("[TB] FAIL stream_sat got %b expected %b", sat_flag, exp_sat); end
        if (term_err !== exp_terr) begin failures++; $display("[TB] FAIL stream_terr got %b expected %b", term_err, exp_terr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_term_err();
        test_reset_mid_run();
        test_streaming();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
